// File: rtl/store_pkg.sv
`default_nettype none
// ============================================================================
// Module      : store_pkg
// Description : Shared types and sizing helpers for the store_bank slice.
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
package store_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Channel index width; never narrower than one bit.
    function automatic int f_idx_w(input int ch);
        return (ch < 2) ? 1 : $clog2(ch);
    endfunction

    function automatic int f_maxcnt(input int cw);
        return (1 << cw) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_cnt.sv
`default_nettype none
// ============================================================================
// Module      : store_cnt
// Description : One run-length counter; saturating or wrapping increment.
//               Macro STORE_BANK_DECAY_EN: decrement-to-floor instead of clear.
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
module store_cnt
    import store_pkg::*;
#(
    parameter int CW   = 3,
    parameter int WRAP = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          upd,
    input  logic          cur,
    output logic [CW-1:0] count,
    output logic          sat
);

    localparam logic [CW-1:0] c_MAX = CW'(f_maxcnt(CW));

    logic [CW-1:0] r_count;
    logic          r_sat;
    logic [CW-1:0] w_next;

    always_comb begin
        w_next = r_count;
        if (upd) begin
            if (cur) begin
                // Natural CW-bit overflow provides the wrap to zero.
                if ((r_count != c_MAX) || (WRAP != 0)) begin
                    w_next = r_count + 1'b1;
                end
            end else begin
`ifdef STORE_BANK_DECAY_EN
                if (r_count != '0) begin
                    w_next = r_count - 1'b1;
                end
`else
                w_next = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_count <= w_next;
            r_sat   <= (w_next == c_MAX);
        end
    end

    assign count = r_count;
    assign sat   = r_sat;

endmodule
`default_nettype wire

// File: rtl/store_bank.sv
`default_nettype none
// ============================================================================
// Module      : store_bank
// Description : CH run-length counters with an atomic snapshot streamed out
//               one channel per valid/ready beat. Honours STORE_BANK_DECAY_EN.
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
module store_bank
    import store_pkg::*;
#(
    parameter int CH   = 4,
    parameter int CW   = 3,
    parameter int TW   = 3,
    parameter int WRAP = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CH-1:0]          current,
    input  logic [TW-1:0]          trigger,
    input  logic                   snap_req,
    output logic [CH*CW-1:0]       dc_control,
    output logic [CH-1:0]          sat,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [f_idx_w(CH)-1:0] out_ch,
    output logic [CW-1:0]          out_count,
    output logic                   out_last,
    output logic                   busy
);

    localparam int              IW     = f_idx_w(CH);
    localparam logic [IW-1:0]   c_LAST = IW'(CH - 1);

    logic          w_upd;
    logic [CW-1:0] w_count [CH];

    assign w_upd = (trigger == '0);

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            store_cnt #(
                .CW   (CW),
                .WRAP (WRAP)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .upd   (w_upd),
                .cur   (current[gi]),
                .count (w_count[gi]),
                .sat   (sat[gi])
            );
            assign dc_control[gi*CW +: CW] = w_count[gi];
        end
    endgenerate

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_idx_nxt;
    logic          w_capture;
    logic [CW-1:0] r_shadow [CH];

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (snap_req) begin
                    w_capture   = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (r_idx == c_LAST) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Shadows sample the counter registers, i.e. the pre-update value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            for (int i = 0; i < CH; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_capture) begin
                for (int i = 0; i < CH; i++) begin
                    r_shadow[i] <= w_count[i];
                end
            end
        end
    end

    assign out_valid = (r_state == SEND);
    assign busy      = (r_state == SEND);
    assign out_ch    = r_idx;
    assign out_count = r_shadow[r_idx];
    assign out_last  = (r_state == SEND) && (r_idx == c_LAST);

endmodule
`default_nettype wire

// File: doc/store_bank.md
Name: store_bank

Overview:
- Multi-channel, parametrised successor to the single-channel 3-bit store counter.
- Each channel holds a run-length counter. On each update cycle the counter increments while its `current` input is high, and clears (or decays) when it is low.
- A snapshot engine captures all channel counts atomically. It then streams them out one channel per transfer over a valid/ready handshake to the downstream DC-control logic.

Parameters:
- CH, 4, number of channels (must be >= 2).
- CW, 3, counter width per channel; max count is 2^CW-1.
- TW, 3, trigger width.
- WRAP, 0, 0 = saturate at max count, 1 = wrap from max to 0.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- current  in  CH  per-channel count-enable level.
- trigger  in  TW  update qualifier; an update occurs only in cycles where trigger == 0.
- snap_req  in  1  single-cycle request to capture and stream all counts.
- dc_control  out  CH*CW  live counts; channel i occupies bits [i*CW +: CW].
- sat  out  CH  per-channel flag, 1 when that live count == 2^CW-1.
- out_valid  out  1  stream data valid.
- out_ready  in  1  downstream ready.
- out_ch  out  clog2(CH)  channel index of the current beat.
- out_count  out  CW  captured count for out_ch.
- out_last  out  1  high on the beat where out_ch == CH-1.
- busy  out  1  high while streaming (state SEND).

Behaviour:
- Reset (rst high at a clk edge):
  - All counters, shadow registers and the index clear to 0.
  - State goes to IDLE; out_valid = 0 and busy = 0.
  - Reset has priority over every other event, including mid-stream; a stream in progress is abandoned with no further beats.
- Counter update (upd = (trigger == 0)); channels are fully independent:
  - upd and current[i] = 1:
    - WRAP = 0: count increments if below max, otherwise holds at max.
    - WRAP = 1: count increments modulo 2^CW.
  - upd and current[i] = 0: count clears to 0.
  - upd = 0: count holds.
- sat[i] and dc_control are driven directly from registers, with no combinational path from the inputs.
- State machine, states IDLE and SEND:
  - IDLE, snap_req = 1:
    - Shadow[i] takes the pre-update register value of counter i, i.e. the value at the start of the cycle, not including that cycle's update.
    - idx becomes 0 and the state goes to SEND.
  - SEND:
    - out_valid = 1, out_ch = idx, out_count = shadow[idx], out_last = (idx == CH-1).
    - A transfer occurs on out_valid & out_ready.
    - On a transfer with out_last = 0, idx increments.
    - On a transfer with out_last = 1, the state returns to IDLE and out_valid drops the next cycle.
  - While out_valid is high and out_ready is low, out_ch, out_count and out_last hold stable.
  - snap_req is ignored while in SEND; there is no queueing.
  - Counters continue to update during SEND; the shadow registers are unaffected.
- Latency:
  - snap_req sampled at edge n gives out_valid = 1 after edge n.
  - The minimum stream length is CH cycles.
  - With out_ready held high, snap_req may be re-accepted on the cycle after the last beat (the cycle in which the state is back in IDLE).

Optional Feature:
- Macro STORE_BANK_DECAY_EN.
- Defined: on an update with current[i] = 0, count[i] decrements by 1 with a floor at 0, instead of clearing.
- Undefined: count clears to 0 as specified above.
- Increment behaviour is unchanged either way.

Decomposition:
- Package store_pkg holds:
  - the state enum (IDLE, SEND);
  - a function for the index width, clog2(CH);
  - the constant MAXCNT = 2^CW-1, computed as a function of CW.
- Sub-module store_cnt: one CW-bit counter.
  - Inputs: clk, rst, upd, cur.
  - Parameter: WRAP.
  - Outputs: count, sat.
  - It carries the STORE_BANK_DECAY_EN logic.
- store_bank instantiates CH copies of store_cnt and contains the snapshot FSM.

Test Plan:
- Reset values: rst held 2 cycles -> dc_control = 0, sat = 0, out_valid = 0, busy = 0.
- Saturation: CH = 4, CW = 3, WRAP = 0, current = 4'b0001, trigger = 0 for 10 cycles -> ch0 = 7 with sat[0] = 1 and holding; other channels = 0.
- Wrap: WRAP = 1, ch0 counting for 9 cycles -> ch0 = 1.
- Trigger gating: trigger = 3'b010 with current toggling -> all counts unchanged.
- Clear vs decay: ch1 = 5, then current[1] = 0 with trigger = 0 for one cycle -> ch1 = 0 without the macro, ch1 = 4 with STORE_BANK_DECAY_EN defined.
- Snapshot with backpressure:
  - Setup: counts {3, 7, 0, 2}, pulse snap_req while counts keep changing.
  - Hold out_ready low for 3 cycles -> beat 0 held stable (out_ch = 0, out_count = 3).
  - Then hold out_ready high -> beats 3, 7, 0, 2 with out_last only on ch3.
  - A second snap_req during SEND is ignored.
  - rst asserted mid-stream -> out_valid = 0 on the next cycle.
